rr_stream_mux: RTL and testbench
================================

# rr_stream_mux

Parametrised N-to-1 streaming multiplexer with round-robin arbitration and a registered output stage. It succeeds the gate-level 2:1 and 4:1 muxes. Selection comes from a fair arbiter driven by per-channel valid/ready handshakes, not from an external select input. It sits between several producer channels and a single consumer, for example merging lab peripherals onto one bus.

## Interface
- `N`, default 4: number of input channels; legal range 2..16, any value including non-powers-of-two.
- `W`, default 8: data width per channel; legal W ≥ 1.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `in_data`  in  N*W: channel i occupies bits [i*W+W-1 : i*W].
- `in_valid`  in  N: channel i offers a word.
- `in_ready`  out  N: channel i's word is taken this cycle; at most one bit is set.
- `out_data`  out  W: registered output word.
- `out_valid`  out  1: `out_data` holds a word.
- `out_ready`  in  1: consumer accepts the word this cycle.
- `out_src`  out  $clog2(N): index of the channel that supplied `out_data`. Present only with `RR_MUX_SRCID_EN`.

## Operation
- Output register behaves as a two-state FSM tracked by `out_valid`:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- `drain` = `out_valid` & `out_ready`.
- `load` = (any `in_valid`) & (!`out_valid` | `out_ready`).
- Transitions:
  - EMPTY→FULL on `load`.
  - FULL→FULL on `load` while draining, giving back-to-back transfers.
  - FULL→EMPTY on `drain` & !`load`.
  - FULL holds data unchanged while !`out_ready`.
- Arbiter: round-robin pointer `ptr` (0..N-1).
  - Grant `g` is the first index with `in_valid` set, searching `ptr`, `ptr`+1, … with wrap modulo N.
  - On `load`, `ptr` ← (g+1) mod N. For N not a power of two, N-1 wraps to 0, never to N.
  - Without `load`, `ptr` holds.
- `in_ready[g]` = `load`. All other `in_ready` bits are 0.
- `in_ready` is combinational from `in_valid`, `out_valid` and `out_ready`. Producers must not make `in_valid` depend on `in_ready`.
- On `load`:
  - `out_data` ← channel g's word.
  - `out_src` ← g (when the macro is defined).
- Simultaneous requests: exactly one channel is served per transfer. Every continuously requesting channel is served within N transfers.
- A channel dropping `in_valid` before it is granted loses nothing; its request is simply not counted.
- Reset values: `out_valid`=0, `out_data`=0, `ptr`=0, `out_src`=0. `in_ready` is all 0 while `reset` is high.
- Reset asserted mid-operation: a held word is discarded and `out_valid` falls asynchronously, without waiting for a clock edge.

## Timing
- Latency: an input handshake at edge k makes the word visible on `out_data`/`out_valid` after edge k.
- Throughput: 1 word/cycle with `out_ready` held high.
- No combinational path from `in_data` to `out_data`.
- The `out_ready`→`in_ready` path is combinational, one level deep.

## Configuration
- `RR_MUX_SRCID_EN` defined:
  - `out_src` port exists.
  - It is registered alongside `out_data` and holds with it while stalled.
- `RR_MUX_SRCID_EN` undefined:
  - Port and register are absent.
  - All other behaviour and timing are identical.

## Structure
- Package `rr_mux_pkg`:
  - Function `ptr_width(n)` returning max(1, $clog2(n)).
  - Constant `RR_MUX_MAX_N` = 16, checked by an elaboration-time assertion on `N`.
- Sub-module `rr_arbiter` (parameter N):
  - Inputs: `clk`, `reset`, `req[N]`, `advance`.
  - Outputs: one-hot `grant[N]` and binary `grant_idx`.
  - Owns `ptr`.
- Top level owns the output register and handshake logic.

## Test plan
- Reset: hold `reset` with `in_valid`=4'b1111. Required: `out_valid`=0, `in_ready`=0, `out_data`=0. After release, the first grant goes to channel 0.
- Fairness: N=4, all channels valid with data 8'hA0..8'hA3, `out_ready`=1. Required: outputs A0, A1, A2, A3, A0 on consecutive cycles.
- Skip idle channels: only channels 1 and 3 valid, `ptr`=0. Required: grant order 1, 3, 1, 3.
- Backpressure: `out_ready`=0 for 3 cycles while FULL with 8'h5C. Required: `out_data` stays 8'h5C, `in_ready`=0, `ptr` unchanged. Release `out_ready`: the next word loads in the same cycle as the drain.
- Odd N wrap: N=3, all channels valid. Required: grants 0, 1, 2, 0 and `ptr` never equals 3. With the macro defined, `out_src` tracks 0, 1, 2, 0.
- Reset mid-transfer: assert `reset` asynchronously between edges while FULL. Required: `out_valid` falls before the next edge and the held word is never delivered.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants, types and helpers for the round-robin stream mux.
package rr_mux_pkg;
  localparam int RR_MUX_MAX_N = 16;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;
  function automatic int ptr_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter; grant searches from ptr upward with wrap, ptr moves past the winner on advance.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = ptr_width(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);
  logic [PW-1:0] ptr;
  logic          found;
  int            idx;
  always_comb begin
    grant_idx = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    grant = found ? N'(1) << grant_idx : '0;
  end
  // explicit wrap so non-power-of-two N never lands on N
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (advance) ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-to-1 round-robin stream mux with a registered output stage.
// Define RR_MUX_SRCID_EN to add the registered out_src channel index.
module rr_stream_mux
  import rr_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int PW = ptr_width(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
`ifdef RR_MUX_SRCID_EN
  output logic [PW-1:0]  out_src,
`endif
  input  logic           out_ready
);
  out_state_t    state_q, state_d;
  logic [N-1:0]  grant;
  logic [PW-1:0] grant_idx;
  logic          drain, load;
  if (N < 2 || N > RR_MUX_MAX_N) begin : g_bad_n
    $error("rr_stream_mux: N=%0d outside 2..%0d", N, RR_MUX_MAX_N);
  end
  assign out_valid = state_q == FULL;
  assign drain = out_valid & out_ready;
  // reset gating keeps in_ready low while the register is held empty
  assign load = !reset & (|in_valid) & (!out_valid | out_ready);
  assign in_ready = load ? grant : '0;
  rr_arbiter #(.N(N)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .advance   (load),
    .grant     (grant),
    .grant_idx (grant_idx)
  );
  always_comb state_d = load ? FULL : drain ? EMPTY : state_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= EMPTY;
    else state_q <= state_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) out_data <= '0;
    else if (load) out_data <= in_data[int'(grant_idx)*W +: W];
`ifdef RR_MUX_SRCID_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) out_src <= '0;
    else if (load) out_src <= grant_idx;
`endif
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: randomized + directed scoreboard bench for rr_stream_mux (N=4 main, N=3 wrap instance).
module tb_rr_stream_mux;
  localparam int N = 4;
  localparam int W = 8;
  typedef struct {logic [W-1:0] d; logic [1:0] s;} item_t;
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [3*W-1:0] in_data3 = '0;
  logic [2:0]     in_valid3 = '0;
  logic [2:0]     in_ready3;
  logic [W-1:0]   out_data3;
  logic           out_valid3;
  logic           out_ready3 = 1'b1;
`ifdef RR_MUX_SRCID_EN
  logic [1:0]     out_src;
  logic [1:0]     out_src3;
`endif
  item_t q[$];
  int mptr = 0;
  int checks = 0;
  int errors = 0;

  rr_stream_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef RR_MUX_SRCID_EN
    .out_src   (out_src),
`endif
    .out_ready (out_ready)
  );

  rr_stream_mux #(.N(3), .W(W)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
`ifdef RR_MUX_SRCID_EN
    .out_src   (out_src3),
`endif
    .out_ready (out_ready3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one-word output buffer as a queue, grant = first valid channel at or after mptr.
  always @(negedge clk) begin : model
    bit full, ld, found;
    int g, c;
    #3;
    full = q.size() != 0;
    check("out_valid", {31'b0, out_valid}, {31'b0, full});
    ld = !reset && (in_valid != 0) && (!full || out_ready);
    g = 0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = (mptr + k) % N;
      if (!found && in_valid[c]) begin
        found = 1'b1;
        g = c;
      end
    end
    check("in_ready", {28'b0, in_ready}, ld ? (32'd1 << g) : 32'd0);
    if (ld) begin
      q.push_back('{d: in_data[g*W +: W], s: 2'(g)});
      mptr = (g + 1) % N;
    end
  end

  // Monitor: compares the presented word against the oldest expected one, pops on handshake.
  always @(negedge clk) begin : monitor
    #4;
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_data unexpected word actual=%0h required=none at %0t", out_data, $time);
      end else begin
        check("out_data", {24'b0, out_data}, {24'b0, q[0].d});
`ifdef RR_MUX_SRCID_EN
        check("out_src", {30'b0, out_src}, {30'b0, q[0].s});
`endif
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    q.delete();
    mptr = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    in_valid = 4'hF;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    repeat (3) @(negedge clk);
    #2;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset in_ready", {28'b0, in_ready}, 32'd0);
    check("reset out_data", {24'b0, out_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #2;
      if (i < 5) check("fair grant", {28'b0, in_ready}, 32'd1 << (i % 4));
      if (i > 0) check("fair data", {24'b0, out_data}, 32'hA0 + ((i - 1) % 4));
      @(negedge clk);
    end
    in_valid = '0;
    do_reset();
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #2 check("skip idle grant", {28'b0, in_ready}, (i % 2 == 0) ? 32'h2 : 32'h8);
      @(negedge clk);
    end
    in_valid = '0;
    do_reset();
    in_valid = 4'b0001;
    in_data = {8'h00, 8'h00, 8'h77, 8'h5C};
    out_ready = 1'b0;
    #2 check("bp first grant", {28'b0, in_ready}, 32'h1);
    @(negedge clk);
    in_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("bp hold data", {24'b0, out_data}, 32'h5C);
      check("bp hold valid", {31'b0, out_valid}, 32'd1);
      check("bp in_ready", {28'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #2 check("bp release grant", {28'b0, in_ready}, 32'h2);
    @(negedge clk);
    in_valid = '0;
    out_ready = 1'b0;
    #2 check("bp next word", {24'b0, out_data}, 32'h77);
    @(negedge clk);
    #1 reset = 1'b1;
    q.delete();
    mptr = 0;
    #1 check("async reset valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 check("no stale word", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end
    do_reset();
    in_valid3 = 3'b111;
    in_data3 = {8'h32, 8'h31, 8'h30};
    for (int i = 0; i < 5; i++) begin
      #2;
      if (i < 4) check("n3 grant", {29'b0, in_ready3}, 32'd1 << (i % 3));
      if (i > 0) begin
        check("n3 data", {24'b0, out_data3}, 32'h30 + ((i - 1) % 3));
`ifdef RR_MUX_SRCID_EN
        check("n3 src", {30'b0, out_src3}, 32'((i - 1) % 3));
`endif
      end
      @(negedge clk);
    end
    in_valid3 = '0;
    for (int i = 0; i < 600; i++) begin
      in_valid = 4'($urandom);
      in_data = $urandom;
      out_ready = ($urandom % 4) != 0;
      @(negedge clk);
    end
    in_valid = '0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #5 check("queue drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
